// File: rtl/add_pipe_seg_if.sv
// Handshake and data bundle for the segmented adder pipeline.
// The issuing unit drives the master modport; the adder sits on the slave side.
interface add_pipe_seg_if #(
    parameter int DATA_LEN = 32,
    parameter int TAG_LEN  = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] OP_A;
    logic [DATA_LEN-1:0] OP_B;
    logic                Cin;
    logic                sub;
    logic [TAG_LEN-1:0]  in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] Sum;
    logic                Cout;
    logic                ovf;
    logic                zero;
    logic [TAG_LEN-1:0]  out_tag;

    modport master (
        output in_valid, OP_A, OP_B, Cin, sub, in_tag, out_ready,
        input  in_ready, out_valid, Sum, Cout, ovf, zero, out_tag
    );

    modport slave (
        input  in_valid, OP_A, OP_B, Cin, sub, in_tag, out_ready,
        output in_ready, out_valid, Sum, Cout, ovf, zero, out_tag
    );
endinterface

// File: rtl/add_pipe_seg.sv
// Pipelined segmented adder/subtractor. Stage k resolves bits
// [k*SEG_LEN +: SEG_LEN]; the last stage register doubles as the output
// register, so Sum/Cout/ovf/zero/out_tag are all flop outputs. The whole
// pipeline advances together whenever the output slot is empty or being taken.
module add_pipe_seg #(
    parameter int DATA_LEN = 32,
    parameter int SEG_LEN  = 8,
    parameter int TAG_LEN  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    add_pipe_seg_if.slave bus
);
    localparam int NSEG = DATA_LEN / SEG_LEN;
    localparam int LAST = NSEG - 1;

    // Per-stage state: operands travel with the op so later stages can pick
    // their own segment; already-resolved sum segments accumulate in s_r.
    logic [DATA_LEN-1:0] a_r   [NSEG];
    logic [DATA_LEN-1:0] b_r   [NSEG];
    logic [DATA_LEN-1:0] s_r   [NSEG];
    logic                c_r   [NSEG];
    logic                v_r   [NSEG];
    logic [TAG_LEN-1:0]  tag_r [NSEG];
    logic                ovf_r;
    logic                zero_r;

    // Stage inputs (what each stage will capture on an advancing edge).
    logic [DATA_LEN-1:0] a_in_s   [NSEG];
    logic [DATA_LEN-1:0] b_in_s   [NSEG];
    logic [DATA_LEN-1:0] s_in_s   [NSEG];
    logic                c_in_s   [NSEG];
    logic                v_in_s   [NSEG];
    logic [TAG_LEN-1:0]  tag_in_s [NSEG];

    // Stage results.
    logic [SEG_LEN:0]    seg_sum_s [NSEG];
    logic [DATA_LEN-1:0] s_nxt_s   [NSEG];
    logic                c_nxt_s   [NSEG];
    logic                ovf_nxt_s;
    logic                zero_nxt_s;
    logic                en_s;

    // The pipeline moves only when the output slot is free or being drained.
    assign en_s = !v_r[LAST] || bus.out_ready;

    // Stage 0 takes the new operation (B already inverted for subtract);
    // every later stage takes the registers of the stage before it.
    always_comb begin
        a_in_s[0]   = bus.OP_A;
        b_in_s[0]   = bus.sub ? ~bus.OP_B : bus.OP_B;
        s_in_s[0]   = {DATA_LEN{1'b0}};
        c_in_s[0]   = bus.Cin;
        v_in_s[0]   = bus.in_valid;
        tag_in_s[0] = bus.in_tag;
        for (int k = 1; k < NSEG; k++) begin
            a_in_s[k]   = a_r[k-1];
            b_in_s[k]   = b_r[k-1];
            s_in_s[k]   = s_r[k-1];
            c_in_s[k]   = c_r[k-1];
            v_in_s[k]   = v_r[k-1];
            tag_in_s[k] = tag_r[k-1];
        end
    end

    // Each stage adds its own segment with the incoming carry and splices the
    // result into the partial sum it carries forward.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            seg_sum_s[k] = {1'b0, a_in_s[k][k*SEG_LEN +: SEG_LEN]}
                         + {1'b0, b_in_s[k][k*SEG_LEN +: SEG_LEN]}
                         + {{SEG_LEN{1'b0}}, c_in_s[k]};
            s_nxt_s[k] = s_in_s[k];
            s_nxt_s[k][k*SEG_LEN +: SEG_LEN] = seg_sum_s[k][SEG_LEN-1:0];
            c_nxt_s[k] = seg_sum_s[k][SEG_LEN];
        end
    end

    // Flags are formed as the final segment resolves so they register with Sum.
    always_comb begin
        ovf_nxt_s  = (a_in_s[LAST][DATA_LEN-1] == b_in_s[LAST][DATA_LEN-1])
                  && (s_nxt_s[LAST][DATA_LEN-1] != a_in_s[LAST][DATA_LEN-1]);
        zero_nxt_s = ~|s_nxt_s[LAST];
    end

    // Pipeline registers: reset clears everything, flush drops valid bits only,
    // and data moves only alongside a valid op so bubbles never disturb Sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                v_r[k]   <= 1'b0;
                a_r[k]   <= {DATA_LEN{1'b0}};
                b_r[k]   <= {DATA_LEN{1'b0}};
                s_r[k]   <= {DATA_LEN{1'b0}};
                c_r[k]   <= 1'b0;
                tag_r[k] <= {TAG_LEN{1'b0}};
            end
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < NSEG; k++) begin
                v_r[k] <= 1'b0;
            end
        end else if (en_s) begin
            for (int k = 0; k < NSEG; k++) begin
                v_r[k] <= v_in_s[k];
                if (v_in_s[k]) begin
                    a_r[k]   <= a_in_s[k];
                    b_r[k]   <= b_in_s[k];
                    s_r[k]   <= s_nxt_s[k];
                    c_r[k]   <= c_nxt_s[k];
                    tag_r[k] <= tag_in_s[k];
                end
            end
            if (v_in_s[LAST]) begin
                ovf_r  <= ovf_nxt_s;
                zero_r <= zero_nxt_s;
            end
        end
    end

    assign bus.in_ready  = en_s;
    assign bus.out_valid = v_r[LAST];
    assign bus.Sum       = s_r[LAST];
    assign bus.Cout      = c_r[LAST];
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
    assign bus.out_tag   = tag_r[LAST];
endmodule

// File: tb/tb_add_pipe_seg.sv
// Directed bench for add_pipe_seg: a 4-stage instance for ripple, overflow,
// subtract, backpressure, flush and reset, plus a single-stage instance.
module tb_add_pipe_seg;
    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   errors;

    add_pipe_seg_if #(.DATA_LEN(32), .TAG_LEN(4)) bus0 ();
    add_pipe_seg_if #(.DATA_LEN(32), .TAG_LEN(4)) bus1 ();

    add_pipe_seg #(.DATA_LEN(32), .SEG_LEN(8),  .TAG_LEN(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0)
    );
    add_pipe_seg #(.DATA_LEN(32), .SEG_LEN(32), .TAG_LEN(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sb, input logic [3:0] tg);
        bus0.OP_A     = a;
        bus0.OP_B     = b;
        bus0.Cin      = cin;
        bus0.sub      = sb;
        bus0.in_tag   = tg;
        bus0.in_valid = 1'b1;
    endtask

    logic [31:0] sa;
    logic [31:0] sb_v;
    logic [35:0] expq [$];
    logic [35:0] e;
    logic [31:0] hold_sum;
    logic [3:0]  hold_tag;
    int          issued;
    int          got;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        bus0.OP_A = 32'h0; bus0.OP_B = 32'h0; bus0.Cin = 1'b0; bus0.sub = 1'b0; bus0.in_tag = 4'h0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        bus1.OP_A = 32'h0; bus1.OP_B = 32'h0; bus1.Cin = 1'b0; bus1.sub = 1'b0; bus1.in_tag = 4'h0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_in_ready",  bus0.in_ready, 1);
        chk("rst_sum",       bus0.Sum, 0);
        chk("rst_cout",      bus0.Cout, 0);
        chk("rst_ovf",       bus0.ovf, 0);
        chk("rst_zero",      bus0.zero, 0);
        chk("rst_tag",       bus0.out_tag, 0);
        chk("rst_d1_valid",  bus1.out_valid, 0);

        // Carry ripple across all segments
        set_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h1);
        tick();
        bus0.in_valid = 1'b0;
        tick();
        tick();
        chk("rip_latency", bus0.out_valid, 0);
        tick();
        chk("rip_valid", bus0.out_valid, 1);
        chk("rip_sum",   bus0.Sum, 32'h00000000);
        chk("rip_cout",  bus0.Cout, 1);
        chk("rip_ovf",   bus0.ovf, 0);
        chk("rip_zero",  bus0.zero, 1);
        chk("rip_tag",   bus0.out_tag, 4'h1);

        // Signed overflow then subtract, back to back
        set_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h2);
        tick();
        set_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 4'h3);
        tick();
        bus0.in_valid = 1'b0;
        tick();
        tick();
        chk("ovf_valid", bus0.out_valid, 1);
        chk("ovf_sum",   bus0.Sum, 32'h80000000);
        chk("ovf_ovf",   bus0.ovf, 1);
        chk("ovf_cout",  bus0.Cout, 0);
        chk("ovf_tag",   bus0.out_tag, 4'h2);
        tick();
        chk("sub_valid", bus0.out_valid, 1);
        chk("sub_sum",   bus0.Sum, 32'hFFFFFFFE);
        chk("sub_cout",  bus0.Cout, 0);
        chk("sub_ovf",   bus0.ovf, 0);
        chk("sub_zero",  bus0.zero, 0);
        chk("sub_tag",   bus0.out_tag, 4'h3);
        tick();
        chk("sub_drain", bus0.out_valid, 0);

        // Streaming 8 ops with a 3-cycle output stall
        issued = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            bus0.out_ready = !(cyc >= 5 && cyc < 8);
            if (issued < 8) begin
                sa   = 32'h11111111 * issued;
                sb_v = 32'hF0F0F0F1;
                set_op(sa, sb_v, 1'b0, 1'b0, issued[3:0]);
            end else begin
                bus0.in_valid = 1'b0;
            end
            #1;
            if (cyc >= 5 && cyc < 8) begin
                chk("bp_in_ready", bus0.in_ready, 0);
                chk("bp_valid_held", bus0.out_valid, 1);
                if (cyc == 5) begin
                    hold_sum = bus0.Sum;
                    hold_tag = bus0.out_tag;
                end else begin
                    chk("bp_sum_stable", bus0.Sum, hold_sum);
                    chk("bp_tag_stable", bus0.out_tag, hold_tag);
                end
            end
            if (bus0.in_valid && bus0.in_ready) begin
                expq.push_back({issued[3:0], sa + sb_v});
                issued++;
            end
            if (bus0.out_valid && bus0.out_ready) begin
                chk("bp_not_extra", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("bp_sum", bus0.Sum, e[31:0]);
                    chk("bp_tag", bus0.out_tag, e[35:32]);
                end
                got++;
            end
            tick();
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        chk("bp_count",  got, 8);
        chk("bp_issued", issued, 8);
        chk("bp_queue_empty", expq.size(), 0);
        chk("bp_drain", bus0.out_valid, 0);

        // Flush with three ops in flight
        set_op(32'h00000010, 32'h00000001, 1'b0, 1'b0, 4'hA);
        tick();
        set_op(32'h00000020, 32'h00000002, 1'b0, 1'b0, 4'hB);
        tick();
        set_op(32'h00000030, 32'h00000003, 1'b0, 1'b0, 4'hC);
        tick();
        set_op(32'h00000003, 32'h00000003, 1'b0, 1'b0, 4'hE);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_clear", bus0.out_valid, 0);
        set_op(32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 4'h9);
        tick();
        bus0.in_valid = 1'b0;
        chk("fl_empty1", bus0.out_valid, 0);
        tick();
        chk("fl_empty2", bus0.out_valid, 0);
        tick();
        chk("fl_empty3", bus0.out_valid, 0);
        tick();
        chk("fl_valid", bus0.out_valid, 1);
        chk("fl_sum",   bus0.Sum, 32'h00000001);
        chk("fl_cout",  bus0.Cout, 1);
        chk("fl_tag",   bus0.out_tag, 4'h9);
        tick();
        chk("fl_alone", bus0.out_valid, 0);

        // Reset with two ops in flight
        set_op(32'h00000100, 32'h00000200, 1'b0, 1'b0, 4'h1);
        tick();
        set_op(32'h00000300, 32'h00000400, 1'b0, 1'b0, 4'h2);
        tick();
        bus0.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", bus0.out_valid, 0);
        chk("mr_sum",   bus0.Sum, 0);
        chk("mr_cout",  bus0.Cout, 0);
        set_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 4'h5);
        tick();
        bus0.in_valid = 1'b0;
        chk("mr_stale1", bus0.out_valid, 0);
        tick();
        chk("mr_stale2", bus0.out_valid, 0);
        tick();
        chk("mr_stale3", bus0.out_valid, 0);
        tick();
        chk("mr_new_valid", bus0.out_valid, 1);
        chk("mr_new_sum",   bus0.Sum, 32'h23456789);
        chk("mr_new_tag",   bus0.out_tag, 4'h5);
        tick();

        // Single-stage configuration
        bus1.OP_A = 32'hFFFFFFFF;
        bus1.OP_B = 32'h00000000;
        bus1.Cin = 1'b1;
        bus1.sub = 1'b0;
        bus1.in_tag = 4'h3;
        bus1.in_valid = 1'b1;
        #1;
        chk("d1_pre_valid", bus1.out_valid, 0);
        chk("d1_in_ready",  bus1.in_ready, 1);
        tick();
        bus1.in_valid = 1'b0;
        chk("d1_valid", bus1.out_valid, 1);
        chk("d1_sum",   bus1.Sum, 32'h00000000);
        chk("d1_cout",  bus1.Cout, 1);
        chk("d1_zero",  bus1.zero, 1);
        chk("d1_ovf",   bus1.ovf, 0);
        chk("d1_tag",   bus1.out_tag, 4'h3);
        tick();
        chk("d1_drain", bus1.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
